// File: rtl/dds_spi_master_if.sv
// dds_spi_master_if: request handshake and DDS pin bundle for dds_spi_master.
// Read-back ports (AD_SDO, RDATA) exist only when DDS_SPI_READ_EN is defined.
interface dds_spi_master_if #(
    parameter int MAX_BYTES = 8
);
    localparam int LW = $clog2(MAX_BYTES + 1);
    logic                   VALID;
    logic                   READY;
    logic [7:0]             INSTR;
    logic [8*MAX_BYTES-1:0] DATA;
    logic [LW-1:0]          LEN;
    logic                   UPD;
    logic                   DONE;
    logic                   AD_CS;
    logic                   AD_SCLK;
    logic                   AD_SDIO0;
    logic                   AD_UPDATE;
`ifdef DDS_SPI_READ_EN
    logic                   AD_SDO;
    logic [8*MAX_BYTES-1:0] RDATA;
    modport master (
        input  VALID, INSTR, DATA, LEN, UPD, AD_SDO,
        output READY, DONE, AD_CS, AD_SCLK, AD_SDIO0, AD_UPDATE, RDATA
    );
    modport slave (
        output VALID, INSTR, DATA, LEN, UPD, AD_SDO,
        input  READY, DONE, AD_CS, AD_SCLK, AD_SDIO0, AD_UPDATE, RDATA
    );
`else
    modport master (
        input  VALID, INSTR, DATA, LEN, UPD,
        output READY, DONE, AD_CS, AD_SCLK, AD_SDIO0, AD_UPDATE
    );
    modport slave (
        output VALID, INSTR, DATA, LEN, UPD,
        input  READY, DONE, AD_CS, AD_SCLK, AD_SDIO0, AD_UPDATE
    );
`endif
endinterface

// File: rtl/dds_spi_master.sv
// dds_spi_master: AD99xx serial-port master, instruction byte + LEN data bytes MSB-first,
// optional IO_UPDATE pulse. Define DDS_SPI_READ_EN to enable read-back via AD_SDO/RDATA.
module dds_spi_master #(
    parameter int CLK_DIV   = 2,
    parameter int MAX_BYTES = 8,
    parameter int UPDATE_W  = 4
) (
    input logic CLK,
    input logic RESET,
    dds_spi_master_if.master bus
);
    localparam int LW = $clog2(MAX_BYTES + 1);
    localparam int BW = $clog2(8 * MAX_BYTES + 8);
    localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int UW = UPDATE_W > 1 ? $clog2(UPDATE_W) : 1;
    localparam int DW = 8 * MAX_BYTES;
    localparam int SW = 8 + DW;

    typedef enum logic [2:0] {IDLE, SHIFT, HOLD, CS_UP, UPDATE, FIN} state_t;

    state_t        state;
    logic          ready, done, cs, sclk, sdio, upd_pulse, upd_q, rd_q;
    logic [PW-1:0] ph;
    logic [UW-1:0] uc;
    logic [BW-1:0] bit_cnt, last_bit;
    logic [SW-1:0] sh, frame;
    logic [LW-1:0] len_c;
    logic [7:0]    instr_w;
    logic          accept, ph_end;

    // Clamp LEN and left-align the frame so the first bit to send is the MSB.
    always_comb begin
        len_c   = (bus.LEN > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : bus.LEN;
`ifdef DDS_SPI_READ_EN
        instr_w = bus.INSTR;
`else
        instr_w = {1'b0, bus.INSTR[6:0]};
`endif
        frame   = {instr_w, bus.DATA << (8 * (MAX_BYTES - int'(len_c)))};
        accept  = ready & bus.VALID;
        ph_end  = ph == PW'(CLK_DIV - 1);
    end

    // Transaction FSM: accept, shift bits, hold, optional IO_UPDATE, done.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            ready     <= 1'b0;
            done      <= 1'b0;
            cs        <= 1'b1;
            sclk      <= 1'b0;
            sdio      <= 1'b0;
            upd_pulse <= 1'b0;
            upd_q     <= 1'b0;
            rd_q      <= 1'b0;
            ph        <= '0;
            uc        <= '0;
            bit_cnt   <= '0;
            last_bit  <= '0;
            sh        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (accept) begin
                        state    <= SHIFT;
                        ready    <= 1'b0;
                        cs       <= 1'b0;
                        sclk     <= 1'b0;
                        ph       <= '0;
                        bit_cnt  <= '0;
                        sh       <= frame;
                        sdio     <= frame[SW-1];
                        last_bit <= {len_c, 3'b111};
                        upd_q    <= bus.UPD;
                        rd_q     <= instr_w[7];
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ph_end) begin
                        ph   <= '0;
                        sclk <= ~sclk;
                        if (sclk) begin
                            if (bit_cnt == last_bit) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                sh      <= sh << 1;
                                // Read frames keep SDIO0 low through the data phase.
                                sdio    <= (rd_q && bit_cnt >= BW'(7)) ? 1'b0 : sh[SW-2];
                            end
                        end
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                HOLD: begin
                    if (ph_end) begin
                        ph    <= '0;
                        cs    <= 1'b1;
                        state <= CS_UP;
                    end else begin
                        ph <= ph + 1'b1;
                    end
                end
                CS_UP: begin
                    if (upd_q) begin
                        upd_pulse <= 1'b1;
                        uc        <= '0;
                        state     <= UPDATE;
                    end else begin
                        done  <= 1'b1;
                        ready <= 1'b1;
                        state <= FIN;
                    end
                end
                UPDATE: begin
                    if (uc == UW'(UPDATE_W - 1)) begin
                        upd_pulse <= 1'b0;
                        done      <= 1'b1;
                        ready     <= 1'b1;
                        state     <= FIN;
                    end else begin
                        uc <= uc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DDS_SPI_READ_EN
    logic [DW-1:0] rdata;

    // Shift in AD_SDO in the last CLK of each low phase during read data bits.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            rdata <= '0;
        else if (accept)
            rdata <= '0;
        else if (state == SHIFT && !sclk && ph_end && rd_q && bit_cnt >= BW'(8))
            rdata <= {rdata[DW-2:0], bus.AD_SDO};
    end

    assign bus.RDATA = rdata;
`endif

    assign bus.READY     = ready;
    assign bus.DONE      = done;
    assign bus.AD_CS     = cs;
    assign bus.AD_SCLK   = sclk;
    assign bus.AD_SDIO0  = sdio;
    assign bus.AD_UPDATE = upd_pulse;
endmodule

// File: tb/tb_dds_spi_master.sv
// tb_dds_spi_master: table-driven frames checked by an SPI-decoding scoreboard.
module tb_dds_spi_master;
    localparam int CLK_DIV = 2, MAX_BYTES = 8, UPDATE_W = 4;

    typedef struct {
        logic [7:0]  instr;
        logic [63:0] data;
        logic [3:0]  len;
        logic        upd;
        int          n;
        logic [71:0] bits;
        int          cs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0, n_fail = 0;
    vec_t q[$];
    vec_t vecs[6];
    vec_t cur;

    dds_spi_master_if #(.MAX_BYTES(MAX_BYTES)) bus();
    dds_spi_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .UPDATE_W(UPDATE_W)) dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SPI monitor / scoreboard state
    int          mon_nb = 0, cs_cnt = 0, gap = 0, last_gap = 0, k = 0, upd_cnt = 0, upd_first = 0, frames = 0;
    logic [71:0] mon_bits = '0;
    logic        in_post = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0, prev_done = 1'b0;

`ifdef DDS_SPI_READ_EN
    logic [31:0] sdo_word = 32'hDEAD_BEEF;
    logic [31:0] sdo_sh;
    assign sdo_sh     = sdo_word << (mon_nb - 8);
    assign bus.AD_SDO = (mon_nb >= 8 && mon_nb < 40) ? sdo_sh[31] : 1'b0;
`endif

    always @(negedge clk) begin
        if (rst) begin
            in_post = 1'b0;
            mon_nb  = 0;
        end else begin
            if (!bus.AD_CS && prev_cs) begin
                chk("cs_gap_min", 72'(gap >= 1), 72'(1));
                last_gap = gap;
                mon_nb   = 0;
                mon_bits = '0;
                cs_cnt   = 0;
            end
            if (!bus.AD_CS) begin
                cs_cnt++;
                gap = 0;
                if (bus.AD_SCLK && !prev_sclk) begin
                    mon_bits = {mon_bits[70:0], bus.AD_SDIO0};
                    mon_nb++;
                end
            end else begin
                gap++;
            end
            if (prev_done && bus.DONE) chk("done_width", 72'(bus.DONE), 72'(0));
            if (bus.AD_CS && !prev_cs) begin
                frames++;
                if (q.size() == 0) begin
                    chk("unexpected_frame", 72'(1), 72'(0));
                end else begin
                    cur = q.pop_front();
                    chk("frame_nbits", 72'(mon_nb), 72'(cur.n));
                    chk("frame_bits", mon_bits, cur.bits);
                    chk("cs_low_cycles", 72'(cs_cnt), 72'(cur.cs));
                    chk("ready_busy", 72'(bus.READY), 72'(0));
                    in_post   = 1'b1;
                    k         = 0;
                    upd_cnt   = 0;
                    upd_first = 0;
                end
            end else if (in_post) begin
                k++;
                if (bus.AD_UPDATE) begin
                    if (upd_cnt == 0) upd_first = k;
                    upd_cnt++;
                end
                if (bus.DONE) begin
                    chk("done_delay", 72'(k), 72'(cur.upd ? UPDATE_W + 1 : 1));
                    chk("update_cycles", 72'(upd_cnt), 72'(cur.upd ? UPDATE_W : 0));
                    if (cur.upd) chk("update_start", 72'(upd_first), 72'(1));
                    chk("ready_at_done", 72'(bus.READY), 72'(1));
                    in_post = 1'b0;
                end else if (k > 100) begin
                    chk("done_timeout", 72'(0), 72'(1));
                    in_post = 1'b0;
                end
            end else begin
                if (bus.AD_UPDATE) chk("stray_update", 72'(1), 72'(0));
                if (bus.DONE) chk("stray_done", 72'(1), 72'(0));
            end
        end
        prev_cs   = bus.AD_CS;
        prev_sclk = bus.AD_SCLK;
        prev_done = bus.DONE;
    end

    task automatic scramble();
        bus.INSTR = 8'($urandom);
        bus.DATA  = {$urandom, $urandom};
        bus.LEN   = 4'($urandom);
        bus.UPD   = 1'($urandom);
    endtask

    task automatic send(input vec_t v);
        int w;
        @(negedge clk);
        bus.VALID = 1'b1;
        bus.INSTR = v.instr;
        bus.DATA  = v.data;
        bus.LEN   = v.len;
        bus.UPD   = v.upd;
        w = 0;
        while (!bus.READY && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!bus.READY) begin
            chk("accept_timeout", 72'(0), 72'(1));
            bus.VALID = 1'b0;
            return;
        end
        q.push_back(v);
        @(posedge clk);
        #1;
        bus.VALID = 1'b0;
        scramble();
        w = 0;
        while (!bus.DONE && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("done_seen", 72'(bus.DONE), 72'(1));
    endtask

    initial begin
        int   w, dn, f0;
        logic upd_seen;
        vec_t b;
        vecs[0] = '{8'h04, 64'h0000_0000_1234_5678, 4'd4, 1'b0, 40, 72'h04_1234_5678, 162};
        vecs[1] = '{8'h00, 64'h0000_0000_0000_00F0, 4'd1, 1'b1, 16, 72'h00F0, 66};
        vecs[2] = '{8'h15, 64'hFFFF_FFFF_FFFF_FFFF, 4'd0, 1'b0, 8, 72'h15, 34};
        vecs[3] = '{8'h0A, 64'h0123_4567_89AB_CDEF, 4'd11, 1'b0, 72, 72'h0A_0123_4567_89AB_CDEF, 290};
`ifdef DDS_SPI_READ_EN
        vecs[4] = '{8'h8C, 64'hFFFF_FFFF_FFFF_A55A, 4'd2, 1'b1, 24, 72'h8C_0000, 98};
`else
        vecs[4] = '{8'h8C, 64'hFFFF_FFFF_FFFF_A55A, 4'd2, 1'b1, 24, 72'h0C_A55A, 98};
`endif
        vecs[5] = '{8'h1F, 64'h0000_0000_00AB_CDEF, 4'd3, 1'b1, 32, 72'h1F_ABCDEF, 130};

        bus.VALID = 1'b0;
        scramble();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cs", 72'(bus.AD_CS), 72'(1));
        chk("rst_sclk", 72'(bus.AD_SCLK), 72'(0));
        chk("rst_sdio", 72'(bus.AD_SDIO0), 72'(0));
        chk("rst_update", 72'(bus.AD_UPDATE), 72'(0));
        chk("rst_done", 72'(bus.DONE), 72'(0));
        chk("rst_ready", 72'(bus.READY), 72'(0));
        rst = 1'b0;
        #1 chk("ready_before_edge", 72'(bus.READY), 72'(0));
        @(negedge clk);
        chk("ready_after_release", 72'(bus.READY), 72'(1));

        foreach (vecs[i]) send(vecs[i]);

        // Back-to-back: VALID held high across three frames.
        b  = '{8'h11, 64'h3C, 4'd1, 1'b0, 16, 72'h113C, 66};
        f0 = frames;
        @(negedge clk);
        repeat (3) q.push_back(b);
        bus.VALID = 1'b1;
        bus.INSTR = b.instr;
        bus.DATA  = b.data;
        bus.LEN   = b.len;
        bus.UPD   = b.upd;
        dn = 0;
        w  = 0;
        while (dn < 3 && w < 1000) begin
            @(negedge clk);
            w++;
            if (bus.DONE) dn++;
        end
        bus.VALID = 1'b0;
        chk("b2b_dones", 72'(dn), 72'(3));
        repeat (20) @(negedge clk);
        chk("b2b_frames", 72'(frames - f0), 72'(3));
        chk("b2b_cs_gap", 72'(last_gap), 72'(2));
        chk("b2b_queue_empty", 72'(q.size()), 72'(0));

        // Reset in the middle of an update-requesting frame.
        @(negedge clk);
        bus.VALID = 1'b1;
        bus.INSTR = 8'h04;
        bus.DATA  = 64'h1234_5678;
        bus.LEN   = 4'd4;
        bus.UPD   = 1'b1;
        @(posedge clk);
        #1 bus.VALID = 1'b0;
        w = 0;
        while (mon_nb < 20 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("reached_bit20", 72'(mon_nb >= 20), 72'(1));
        #3 rst = 1'b1;
        #1;
        chk("midrst_cs", 72'(bus.AD_CS), 72'(1));
        chk("midrst_sclk", 72'(bus.AD_SCLK), 72'(0));
        chk("midrst_sdio", 72'(bus.AD_SDIO0), 72'(0));
        chk("midrst_ready", 72'(bus.READY), 72'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("midrst_ready_low", 72'(bus.READY), 72'(0));
        @(negedge clk);
        chk("midrst_ready_up", 72'(bus.READY), 72'(1));
        upd_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            upd_seen = upd_seen | bus.AD_UPDATE | bus.DONE;
        end
        chk("midrst_no_update", 72'(upd_seen), 72'(0));

`ifdef DDS_SPI_READ_EN
        send('{8'h84, 64'hFFFF_FFFF_FFFF_FFFF, 4'd4, 1'b0, 40, 72'h84_0000_0000, 162});
        chk("read_rdata", 72'(bus.RDATA), 72'(64'hDEAD_BEEF));
`endif

        send(vecs[0]);
        repeat (5) @(negedge clk);
        chk("queue_empty", 72'(q.size()), 72'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
